// File: rtl/aes_pkg.sv
// Shared AES-128 decryption types, constants and GF(2^8) helpers.
// Byte 0 of a 128-bit block sits at [127:120]; bytes fill columns first.
package aes_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEYEXP,
    S_INIT,
    S_ROUND,
    S_FINAL
  } state_t;

  localparam logic [3:0] LAST_RND = 4'd10;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // k selects which of a, 2a, 4a, 8a are summed
  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [3:0] k
  );
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return ({8{k[0]}} & a) ^ ({8{k[1]}} & x2) ^
           ({8{k[2]}} & x4) ^ ({8{k[3]}} & x8);
  endfunction

  function automatic logic [127:0] inv_shift_rows(
    input logic [127:0] s
  );
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] =
          s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(
    input logic [127:0] s
  );
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^
                         gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
      o[119-32*c -: 8] = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^
                         gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
      o[111-32*c -: 8] = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^
                         gmul(a2, 4'he) ^ gmul(a3, 4'hb);
      o[103-32*c -: 8] = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^
                         gmul(a2, 4'h9) ^ gmul(a3, 4'he);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Inverse AES S-box, one byte, purely combinational lookup.
// Sixteen copies form the InvSubBytes layer of the core.
module aes_inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [0:255][7:0] TBL = {
    128'h52096ad5_3036a538_bf40a39e_81f3d7fb,
    128'h7ce33982_9b2fff87_348e4344_c4dee9cb,
    128'h547b9432_a6c2233d_ee4c950b_42fac34e,
    128'h082ea166_28d924b2_765ba249_6d8bd125,
    128'h72f8f664_86689816_d4a45ccc_5d65b692,
    128'h6c704850_fdedb9da_5e154657_a78d9d84,
    128'h90d8ab00_8cbcd30a_f7e45805_b8b34506,
    128'hd02c1e8f_ca3f0f02_c1afbd03_01138a6b,
    128'h3a911141_4f67dcea_97f2cfce_f0b4e673,
    128'h96ac7422_e7ad3585_e2f937e8_1c75df6e,
    128'h47f11a71_1d29c589_6fb7620e_aa18be1b,
    128'hfc563e4b_c6d27920_9adbc0fe_78cd5af4,
    128'h1fdda833_8807c731_b1121059_2780ec5f,
    128'h60517fa9_19b54a0d_2de57a9f_93c99cef,
    128'ha0e03b4d_ae2af5b0_c8ebbb3c_83539961,
    128'h172b047e_ba77d626_e1691463_55210c7d
  };

  assign y = TBL[a];

endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box, one byte, purely combinational lookup.
// Used by the key schedule SubWord step.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [0:255][7:0] TBL = {
    128'h637c777b_f26b6fc5_3001672b_fed7ab76,
    128'hca82c97d_fa5947f0_add4a2af_9ca472c0,
    128'hb7fd9326_363ff7cc_34a5e5f1_71d83115,
    128'h04c723c3_1896059a_071280e2_eb27b275,
    128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84,
    128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf,
    128'hd0efaafb_434d3385_45f9027f_503c9fa8,
    128'h51a3408f_929d38f5_bcb6da21_10fff3d2,
    128'hcd0c13ec_5f974417_c4a77e3d_645d1973,
    128'h60814fdc_222a9088_46eeb814_de5e0bdb,
    128'he0323a0a_4906245c_c2d3ac62_9195e479,
    128'he7c8376d_8dd54ea9_6c56f4ea_657aae08,
    128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a,
    128'h703eb566_4803f60e_613557b9_86c11d9e,
    128'he1f89811_69d98e94_9b1e87e9_ce5528df,
    128'h8ca1890d_bfe64268_41992d0f_b054bb16
  };

  assign y = TBL[a];

endmodule

// File: rtl/aes_dec_core.sv
// Iterative AES-128 decryptor: key schedule built once per block,
// then one inverse round per clock; 22 cycles per block.
module aes_dec_core
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic [127:0] data_in,
  output logic         busy,
  output logic         done,
  output logic [31:0]  data_out1,
  output logic [31:0]  data_out2,
  output logic [31:0]  data_out3,
  output logic [31:0]  data_out4
);

  state_t       st, st_nx;
  logic [3:0]   cnt;
  logic [127:0] rk [11];
  logic [127:0] kprev;
  logic [127:0] sq;
  logic [127:0] rk_sel, isr, isb, ark, rk_nx;
  logic [31:0]  rot, sub, t;
  logic [31:0]  w0, w1, w2, w3;

  assign busy   = (st != S_IDLE);
  assign rk_sel = rk[cnt];

  // Key schedule step from the most recent round key
  assign rot = {kprev[23:0], kprev[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sb
    aes_sbox u_sb (
      .a (rot[31-8*i -: 8]),
      .y (sub[31-8*i -: 8])
    );
  end

  assign t     = sub ^ {rcon(cnt), 24'h0};
  assign w0    = kprev[127:96] ^ t;
  assign w1    = kprev[95:64]  ^ w0;
  assign w2    = kprev[63:32]  ^ w1;
  assign w3    = kprev[31:0]   ^ w2;
  assign rk_nx = {w0, w1, w2, w3};

  assign isr = inv_shift_rows(sq);

  for (genvar i = 0; i < 16; i++) begin : g_isb
    aes_inv_sbox u_isb (
      .a (isr[127-8*i -: 8]),
      .y (isb[127-8*i -: 8])
    );
  end

  assign ark = isb ^ rk_sel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st <= S_IDLE;
    else      st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      S_IDLE:   if (start) st_nx = S_KEYEXP;
      S_KEYEXP: if (cnt == LAST_RND) st_nx = S_INIT;
      S_INIT:   st_nx = S_ROUND;
      S_ROUND:  if (cnt == 4'd1) st_nx = S_FINAL;
      S_FINAL:  st_nx = S_IDLE;
      default:  st_nx = S_IDLE;
    endcase
  end

  // cnt stays within 0..10 so it always indexes the key file
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      kprev     <= '0;
      sq        <= '0;
      done      <= 1'b0;
      data_out1 <= '0;
      data_out2 <= '0;
      data_out3 <= '0;
      data_out4 <= '0;
      for (int i = 0; i < 11; i++) rk[i] <= '0;
    end else begin
      done <= 1'b0;
      case (st)
        S_IDLE: begin
          if (start) begin
            rk[0] <= key_in;
            kprev <= key_in;
            sq    <= data_in;
            cnt   <= 4'd1;
          end
        end
        S_KEYEXP: begin
          rk[cnt] <= rk_nx;
          kprev   <= rk_nx;
          if (cnt != LAST_RND) cnt <= cnt + 4'd1;
        end
        S_INIT: begin
          sq  <= sq ^ rk_sel;
          cnt <= 4'd9;
        end
        S_ROUND: begin
          sq  <= inv_mix_columns(ark);
          cnt <= cnt - 4'd1;
        end
        S_FINAL: begin
          data_out1 <= ark[127:96];
          data_out2 <= ark[95:64];
          data_out3 <= ark[63:32];
          data_out4 <= ark[31:0];
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_dec_core.sv
// Scoreboard bench for aes_dec_core using FIPS-197 vectors,
// held/ignored start, output hold and mid-block reset.
module tb_aes_dec_core;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic [127:0] data_in = '0;
  logic         busy, done;
  logic [31:0]  data_out1, data_out2, data_out3, data_out4;

  aes_dec_core dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_in    (key_in),
    .data_in   (data_in),
    .busy      (busy),
    .done      (done),
    .data_out1 (data_out1),
    .data_out2 (data_out2),
    .data_out3 (data_out3),
    .data_out4 (data_out4)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] K_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K_Z  = 128'h0;
  localparam logic [127:0] C_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] P_Z  = 128'h0;

  typedef struct {
    logic [127:0] pt;
    int           at;
    string        nm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] dout();
    return {data_out1, data_out2, data_out3, data_out4};
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // Monitor: every done must match the oldest outstanding block
  always @(negedge clk) begin
    exp_t e;
    if (rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got done=1 at cycle %0d want none",
                 cyc);
      end else begin
        e = sb.pop_front();
        chk({e.nm, "_pt"}, dout(), e.pt);
        chk({e.nm, "_lat"}, 128'(cyc), 128'(e.at));
      end
    end
  end

  // Drive start from a negedge; returns at the negedge after E0
  task automatic issue(logic [127:0] k, logic [127:0] c,
                       logic [127:0] p, string nm);
    key_in  = k;
    data_in = c;
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sb.push_back('{pt: p, at: cyc + 21, nm: nm});
    start   = 1'b0;
    key_in  = $urandom();
    data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic drain(int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    logic all_busy;

    repeat (3) @(negedge clk);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_out", dout(), 128'h0);
    rst = 1'b1;
    @(negedge clk);

    issue(K_C1, C_C1, P_C1, "c1");
    drain(40);

    issue(K_B, C_B, P_B, "appb");
    drain(40);

    issue(K_Z, C_Z, P_Z, "zero");
    all_busy = 1'b1;
    for (int i = 0; i < 21; i++) begin
      all_busy &= busy;
      if (i == 3) chk("out_hold", dout(), P_B);
      @(negedge clk);
    end
    chk("busy_thru", 128'(all_busy), 128'(1));
    chk("busy_fall", 128'(busy), 128'(0));
    drain(10);

    issue(K_C1, C_C1, P_C1, "ign");
    repeat (4) @(negedge clk);
    key_in  = K_B;
    data_in = C_B;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain(40);
    repeat (25) @(negedge clk);

    key_in  = K_C1;
    data_in = C_C1;
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sb.push_back('{pt: P_C1, at: cyc + 21, nm: "held_c1"});
    key_in  = K_B;
    data_in = C_B;
    repeat (22) @(negedge clk);
    sb.push_back('{pt: P_B, at: cyc + 21, nm: "held_b"});
    start = 1'b0;
    drain(60);

    issue(K_C1, C_C1, P_C1, "rstmid");
    repeat (14) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_out", dout(), 128'h0);
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_done", 128'(done), 128'(0));
    sb.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (25) @(negedge clk);
    chk("post_rst_idle", 128'(busy), 128'(0));

    issue(K_C1, C_C1, P_C1, "c1_again");
    drain(40);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
